// File: rtl/multi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_ctrl_pkg
//  Purpose  : Shared constants for the multicycle controller: 4-bit state
//             encoding, opcode values, ALUOp codes (shared with the ALU
//             decoder), datapath mux select codes and the control word type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multi_ctrl_pkg;

    // State encoding
    localparam logic [3:0] c_st_fetch    = 4'd0;
    localparam logic [3:0] c_st_decode   = 4'd1;
    localparam logic [3:0] c_st_memadr   = 4'd2;
    localparam logic [3:0] c_st_memrd    = 4'd3;
    localparam logic [3:0] c_st_memwb    = 4'd4;
    localparam logic [3:0] c_st_memwr    = 4'd5;
    localparam logic [3:0] c_st_execute  = 4'd6;
    localparam logic [3:0] c_st_aluwb    = 4'd7;
    localparam logic [3:0] c_st_branch   = 4'd8;
    localparam logic [3:0] c_st_addiexec = 4'd9;
    localparam logic [3:0] c_st_addiwb   = 4'd10;
    localparam logic [3:0] c_st_jump     = 4'd11;

    // Opcodes
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // ALUOp codes
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALU source B select
    localparam logic [1:0] c_srcb_reg   = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    // PC source select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // Per-state control word. irwrite/pcwrite in FETCH are requests that the
    // top qualifies with MemReady.
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == c_op_lw)   || (op == c_op_sw)  || (op == c_op_rtype) ||
               (op == c_op_beq)  || (op == c_op_addi) || (op == c_op_j);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_main_outdec.sv
`default_nettype none
// ============================================================================
//  Module   : multi_main_outdec
//  Purpose  : Moore output decode: maps the controller state to its control
//             word. Unused/unreachable encodings produce an all-zero word.
//  Ports    : state - current FSM state (4 bits)
//             cw    - decoded control word
//  Revision : 1.0 - initial release
// ============================================================================
module multi_main_outdec
    import multi_ctrl_pkg::*;
(
    input  logic [3:0]  state,
    output ctrl_word_t  cw
);

    always_comb begin
        cw = '0;
        case (state)
            c_st_fetch: begin
                cw.irwrite = 1'b1;
                cw.pcwrite = 1'b1;
                cw.alusrcb = c_srcb_four;
                cw.aluop   = c_aluop_add;
                cw.pcsrc   = c_pcsrc_alu;
            end
            c_st_decode: begin
                cw.alusrcb = c_srcb_immsh;
                cw.aluop   = c_aluop_add;
            end
            c_st_memadr: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = c_srcb_imm;
                cw.aluop   = c_aluop_add;
            end
            c_st_memrd: begin
                cw.iord = 1'b1;
            end
            c_st_memwb: begin
                cw.memtoreg = 1'b1;
                cw.regwrite = 1'b1;
            end
            c_st_memwr: begin
                cw.iord     = 1'b1;
                cw.memwrite = 1'b1;
            end
            c_st_execute: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = c_srcb_reg;
                cw.aluop   = c_aluop_funct;
            end
            c_st_aluwb: begin
                cw.regdst   = 1'b1;
                cw.regwrite = 1'b1;
            end
            c_st_branch: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = c_srcb_reg;
                cw.aluop   = c_aluop_sub;
                cw.pcsrc   = c_pcsrc_aluout;
                cw.branch  = 1'b1;
            end
            c_st_addiexec: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = c_srcb_imm;
                cw.aluop   = c_aluop_add;
            end
            c_st_addiwb: begin
                cw.regwrite = 1'b1;
            end
            c_st_jump: begin
                cw.pcsrc   = c_pcsrc_jump;
                cw.pcwrite = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multi_main_fsm
//  Purpose  : Main controller of a multicycle MIPS-style CPU. Holds the state
//             register and next-state logic; output decode is delegated to
//             multi_main_outdec. Adds MemReady qualification, reset gating of
//             write enables, the IllegalOp flag and PCEn.
//  Ports    : clk, reset (async, active-high), Op[5:0], Zero, MemReady
//             IorD, IRWrite, PCWrite, Branch, PCEn, MemWrite, RegWrite,
//             RegDst, MemtoReg, ALUSrcA, IllegalOp (1 bit each)
//             PCSrc[1:0], ALUSrcB[1:0], ALUOp[1:0]
//  Revision : 1.0 - initial release
// ============================================================================
module multi_main_fsm
    import multi_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       IllegalOp,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    ctrl_word_t w_cw;
    logic       w_in_fetch;
    logic       w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_st_fetch;
        else       r_state <= w_next_state;
    end

    assign w_legal = is_legal_op(Op);

    always_comb begin
        w_next_state = c_st_fetch;
        case (r_state)
            c_st_fetch:    w_next_state = MemReady ? c_st_decode : c_st_fetch;
            c_st_decode: begin
                case (Op)
                    c_op_lw, c_op_sw: w_next_state = c_st_memadr;
                    c_op_rtype:       w_next_state = c_st_execute;
                    c_op_beq:         w_next_state = c_st_branch;
                    c_op_addi:        w_next_state = c_st_addiexec;
                    c_op_j:           w_next_state = c_st_jump;
                    default:          w_next_state = c_st_fetch;
                endcase
            end
            c_st_memadr:   w_next_state = (Op == c_op_lw) ? c_st_memrd : c_st_memwr;
            c_st_memrd:    w_next_state = MemReady ? c_st_memwb : c_st_memrd;
            c_st_memwb:    w_next_state = c_st_fetch;
            c_st_memwr:    w_next_state = MemReady ? c_st_fetch : c_st_memwr;
            c_st_execute:  w_next_state = c_st_aluwb;
            c_st_aluwb:    w_next_state = c_st_fetch;
            c_st_branch:   w_next_state = c_st_fetch;
            c_st_addiexec: w_next_state = c_st_addiwb;
            c_st_addiwb:   w_next_state = c_st_fetch;
            c_st_jump:     w_next_state = c_st_fetch;
            default:       w_next_state = c_st_fetch;
        endcase
    end

    multi_main_outdec u_outdec (
        .state (r_state),
        .cw    (w_cw)
    );

    assign w_in_fetch = (r_state == c_st_fetch);

    // FETCH requests IR/PC writes; they only happen once memory delivers.
    // Write enables are forced low while reset is held, independent of state.
    assign IRWrite   = w_cw.irwrite & MemReady & ~reset;
    assign PCWrite   = w_cw.pcwrite & (~w_in_fetch | MemReady) & ~reset;
    assign MemWrite  = w_cw.memwrite & ~reset;
    assign RegWrite  = w_cw.regwrite & ~reset;
    assign IllegalOp = (r_state == c_st_decode) & ~w_legal & ~reset;
    assign PCEn      = (PCWrite | (w_cw.branch & Zero)) & ~reset;

    assign IorD      = w_cw.iord;
    assign Branch    = w_cw.branch;
    assign RegDst    = w_cw.regdst;
    assign MemtoReg  = w_cw.memtoreg;
    assign ALUSrcA   = w_cw.alusrca;
    assign PCSrc     = w_cw.pcsrc;
    assign ALUSrcB   = w_cw.alusrcb;
    assign ALUOp     = w_cw.aluop;

endmodule
`default_nettype wire

// File: tb/tb_multi_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_main_fsm
//  Purpose  : Self-checking bench for multi_main_fsm. Expected output words
//             are computed from an independent per-state table when the
//             stimulus is applied, queued, and compared when sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_main_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                   S_MEMWB = 4, S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7,
                   S_BRANCH = 8, S_ADDIEXEC = 9, S_ADDIWB = 10, S_JUMP = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD, IRWrite, PCWrite, Branch, PCEn, MemWrite, RegWrite;
    logic       RegDst, MemtoReg, ALUSrcA, IllegalOp;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;

    typedef struct {
        string       tag;
        logic [16:0] word;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    multi_main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .PCEn      (PCEn),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .ALUSrcA   (ALUSrcA),
        .IllegalOp (IllegalOp),
        .PCSrc     (PCSrc),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp)
    );

    // Word layout: IorD IRWrite PCWrite Branch PCEn MemWrite RegWrite RegDst
    //              MemtoReg ALUSrcA IllegalOp PCSrc[1:0] ALUSrcB[1:0] ALUOp[1:0]
    function automatic logic [16:0] exp_word(input int st, input logic mr,
                                             input logic z, input logic [5:0] op,
                                             input logic rst);
        logic iord = 0, irw = 0, pcw = 0, br = 0, pcen, mw = 0, rw = 0;
        logic rd = 0, m2r = 0, asa = 0, ill = 0;
        logic [1:0] pcs = 2'b00, asb = 2'b00, aop = 2'b00;
        case (st)
            S_FETCH:    begin asb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:   begin
                asb = 2'b11;
                ill = !(op inside {6'b100011, 6'b101011, 6'b000000,
                                   6'b000100, 6'b001000, 6'b000010});
            end
            S_MEMADR:   begin asa = 1; asb = 2'b10; end
            S_MEMRD:    iord = 1;
            S_MEMWB:    begin m2r = 1; rw = 1; end
            S_MEMWR:    begin iord = 1; mw = 1; end
            S_EXECUTE:  begin asa = 1; aop = 2'b10; end
            S_ALUWB:    begin rd = 1; rw = 1; end
            S_BRANCH:   begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            S_ADDIEXEC: begin asa = 1; asb = 2'b10; end
            S_ADDIWB:   rw = 1;
            S_JUMP:     begin pcs = 2'b10; pcw = 1; end
            default:    ;
        endcase
        if (rst) begin irw = 0; pcw = 0; mw = 0; rw = 0; ill = 0; end
        pcen = pcw | (br & z);
        return {iord, irw, pcw, br, pcen, mw, rw, rd, m2r, asa, ill, pcs, asb, aop};
    endfunction

    task automatic push_exp(input string tag, input int st);
        exp_t e;
        e.tag  = tag;
        e.word = exp_word(st, MemReady, Zero, Op, reset);
        q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [16:0] obs;
        obs = {IorD, IRWrite, PCWrite, Branch, PCEn, MemWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, IllegalOp, PCSrc, ALUSrcB, ALUOp};
        checks++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %b expected <entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.word) passed++;
            else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.word);
        end
    endtask

    // One clock cycle in an expected state: inputs already applied.
    task automatic cyc(input string tag, input int st);
        push_exp(tag, st);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    // Check combinational response right now, without a clock edge.
    task automatic now_check(input string tag, input int st);
        push_exp(tag, st);
        #1;
        check_pop();
    endtask

    initial begin
        reset = 1'b1; Op = 6'b000000; Zero = 1'b0; MemReady = 1'b0;
        #2;
        now_check("rst_mr0", S_FETCH);
        MemReady = 1'b1;
        now_check("rst_mr1_gated", S_FETCH);
        @(posedge clk); #1;
        reset = 1'b0;

        // FETCH waits for memory
        MemReady = 1'b0; Op = 6'b100011;
        cyc("fetch_wait", S_FETCH);
        MemReady = 1'b1;

        // lw: 5 cycles
        cyc("lw_fetch", S_FETCH);
        cyc("lw_decode", S_DECODE);
        cyc("lw_memadr", S_MEMADR);
        cyc("lw_memrd", S_MEMRD);
        cyc("lw_memwb", S_MEMWB);

        // sw with 3 wait cycles in MEMWR
        Op = 6'b101011;
        cyc("sw_fetch", S_FETCH);
        cyc("sw_decode", S_DECODE);
        cyc("sw_memadr", S_MEMADR);
        MemReady = 1'b0;
        cyc("sw_memwr_w1", S_MEMWR);
        cyc("sw_memwr_w2", S_MEMWR);
        cyc("sw_memwr_w3", S_MEMWR);
        MemReady = 1'b1;
        cyc("sw_memwr_acc", S_MEMWR);

        // beq taken / not taken
        Op = 6'b000100; Zero = 1'b1;
        cyc("beqt_fetch", S_FETCH);
        cyc("beqt_decode", S_DECODE);
        cyc("beqt_branch", S_BRANCH);
        Zero = 1'b0;
        cyc("beqn_fetch", S_FETCH);
        cyc("beqn_decode", S_DECODE);
        cyc("beqn_branch", S_BRANCH);

        // R-type
        Op = 6'b000000;
        cyc("r_fetch", S_FETCH);
        cyc("r_decode", S_DECODE);
        cyc("r_execute", S_EXECUTE);
        cyc("r_aluwb", S_ALUWB);

        // addi
        Op = 6'b001000;
        cyc("addi_fetch", S_FETCH);
        cyc("addi_decode", S_DECODE);
        cyc("addi_exec", S_ADDIEXEC);
        cyc("addi_wb", S_ADDIWB);

        // j
        Op = 6'b000010;
        cyc("j_fetch", S_FETCH);
        cyc("j_decode", S_DECODE);
        cyc("j_jump", S_JUMP);

        // illegal opcode
        Op = 6'b111111;
        cyc("ill_fetch", S_FETCH);
        cyc("ill_decode", S_DECODE);
        cyc("ill_after", S_FETCH);

        // mid-instruction asynchronous reset in MEMRD
        Op = 6'b100011;
        cyc("mid_decode", S_DECODE);
        cyc("mid_memadr", S_MEMADR);
        MemReady = 1'b0;
        cyc("mid_memrd_hold", S_MEMRD);
        #2;
        reset = 1'b1; MemReady = 1'b1;
        now_check("mid_async_rst", S_FETCH);
        @(posedge clk); #1;
        reset = 1'b0;
        Op = 6'b000010;
        cyc("resume_fetch", S_FETCH);
        cyc("resume_decode", S_DECODE);
        cyc("resume_jump", S_JUMP);
        cyc("resume_fetch2", S_FETCH);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_main_fsm.md
MULTI_MAIN_FSM -- requirements
Module: multi_main_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Op  in  6  instruction opcode, from the instruction register.
REQ-004 SHALL have ports: Zero  in  1  ALU zero flag.
REQ-005 SHALL have ports: MemReady  in  1  memory access complete this cycle.
REQ-006 SHALL have outputs, all 1 bit: IorD, IRWrite, PCWrite, Branch, PCEn, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, IllegalOp.
REQ-007 SHALL have outputs, 2 bits: PCSrc, ALUSrcB, and ALUOp. ALUOp encoding: 00 add, 01 sub, 10 use Funct.
REQ-008 SHALL have no parameters.

Function
REQ-009 SHALL be a Moore FSM with 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-010 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSrc=00. It SHALL drive IRWrite=PCWrite=MemReady and stay in FETCH while MemReady=0; on MemReady=1 it SHALL go to DECODE.
REQ-011 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00. Next state on Op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEXEC
- 000010 -> JUMP
- any other Op -> FETCH, with IllegalOp=1 for exactly that cycle.
REQ-012 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00. Next state SHALL be MEMRD if Op=100011, otherwise MEMWR.
REQ-013 MEMRD SHALL drive IorD=1. It SHALL hold while MemReady=0, then go to MEMWB.
REQ-014 MEMWB SHALL drive RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-015 MEMWR SHALL drive IorD=1 and MemWrite=1 until MemReady=1, then go to FETCH. MemWrite SHALL deassert in the cycle after acceptance.
REQ-016 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to ALUWB.
REQ-017 ALUWB SHALL drive RegDst=1, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01 and Branch=1, then go to FETCH.
REQ-019 ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to ADDIWB.
REQ-020 ADDIWB SHALL drive RegDst=0, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-021 JUMP SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-022 Any output not listed for a state SHALL be 0. Unreachable state encodings SHALL return to FETCH on the next edge.
REQ-023 PCEn SHALL equal PCWrite | (Branch & Zero), combinationally, in the same cycle.
REQ-024 Instruction latency in cycles, with MemReady=1 throughout:
- lw: 5
- sw: 4
- R-type: 4
- addi: 4
- beq: 3
- j: 3
- illegal: 2.

Reset
REQ-025 Asserting reset SHALL force state to FETCH immediately, without waiting for a clock edge, including mid-instruction.
REQ-026 While reset=1, IRWrite, PCWrite, PCEn, MemWrite, RegWrite and IllegalOp SHALL be 0. All other outputs SHALL hold their FETCH values.
REQ-027 After reset deasserts, the first rising edge SHALL be evaluated from FETCH.

Structure
REQ-028 Package multi_ctrl_pkg SHALL hold three sets of constants:
- the state encoding, 4 bits
- the six opcode constants
- the ALUOp codes 00/01/10, shared with the ALU decoder.
REQ-029 The per-state output decode SHALL live in sub-module multi_main_outdec (state -> control word). multi_main_fsm SHALL contain only the state register, next-state logic, MemReady/reset gating and PCEn.

Verification
REQ-030 lw sequence: reset pulse, Op=100011, MemReady=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-031 sw with memory wait: Op=101011, MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-032 beq: Op=000100. With Zero=1, PCEn=1 in the BRANCH cycle; with Zero=0, PCEn=0. ALUOp=01 in both cases.
REQ-033 R-type: Op=000000 -> ALUOp=10 in EXECUTE, RegDst=1 and RegWrite=1 in ALUWB.
REQ-034 Illegal opcode: Op=111111 -> IllegalOp=1 for one cycle in DECODE, next state FETCH, no write enable asserted.
REQ-035 Mid-instruction reset: assert reset between edges while in MEMRD -> state becomes FETCH without a clock edge, all write enables 0; fetch resumes after release.
